// File: rtl/pfq_pkg.sv
// Shared types for the instruction prefetch queue: fetch FSM states,
// address/word types and the queue entry layout.
package pfq_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    addr_t pc_next;
  } entry_t;

  // Branch targets are always instruction aligned; low bits are cleared.
  function automatic addr_t word_align(input addr_t a);
    return a & ~addr_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Small flop-based FIFO holding fetched {instr, pc_next} entries with
// wrapping pointers, an occupancy count and a single-cycle flush.
module pfq_fifo
  import pfq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  entry_t                 wdata_i,
  input  logic                   pop_i,
  output entry_t                 rdata_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;
  entry_t        slot_rd [DEPTH];

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      entry_t slot_q;
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          slot_q <= '0;
        end else if (do_push && (wr_ptr_q == PW'(gi))) begin
          slot_q <= wdata_i;
        end
      end
      assign slot_rd[gi] = slot_q;
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = slot_rd[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Handshaked instruction prefetch unit feeding the IF/ID register.
// Define PFQ_BYPASS_EN to forward memory data straight to the outputs when the queue is empty.
module fetch_prefetch_queue
  import pfq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [31:0]            mem_data_i,
  output logic                   instr_valid_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            pc_next_o,
  input  logic                   instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e  state_q, state_d;
  addr_t   fetch_pc_q, fetch_pc_d;
  addr_t   mem_addr_q, mem_addr_d;
  logic    mem_req_q, mem_req_d;

  entry_t  head;
  logic    head_valid;
  logic [CW-1:0] count, count_d;

  logic    ack, live_ack, bypass_take, bypass_used, push, pop;
  addr_t   pc_plus4;
  entry_t  push_entry;

  assign ack      = mem_req_q & mem_ack_i;
  // Only an ack for a request on the current path produces an instruction.
  assign live_ack = ack & (state_q == WAIT) & ~redirect_i;
  assign pc_plus4 = fetch_pc_q + INSTR_BYTES;

`ifdef PFQ_BYPASS_EN
  assign bypass_take = live_ack & ~head_valid;
  assign bypass_used = bypass_take & instr_ready_i;
`else
  assign bypass_take = 1'b0;
  assign bypass_used = 1'b0;
`endif

  assign push       = live_ack & ~bypass_used;
  assign pop        = head_valid & instr_ready_i & ~redirect_i;
  assign push_entry = '{instr: mem_data_i, pc_next: pc_plus4};
  assign count_d    = redirect_i ? '0 : (count + CW'(push) - CW'(pop));

  pfq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (head_valid),
    .count_o (count)
  );

  // A fetch completes on any ack (live or stale); the next request is issued
  // on the same edge whenever the post-update queue still has a free slot.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
    end else if (live_ack) begin
      fetch_pc_d = pc_plus4;
    end

    if ((state_q == FETCH) || ack) begin
      if (count_d < CW'(DEPTH)) begin
        state_d    = WAIT;
        mem_req_d  = 1'b1;
        mem_addr_d = fetch_pc_d;
      end else begin
        state_d    = FETCH;
        mem_req_d  = 1'b0;
      end
    end else if (redirect_i) begin
      state_d = DISCARD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign instr_valid_o = head_valid | bypass_take;
  assign instr_o       = bypass_take ? mem_data_i : head.instr;
  assign pc_next_o     = bypass_take ? pc_plus4 : head.pc_next;
  assign count_o       = count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: a behavioural memory and an
// expected instruction stream (queue) checked by an independent monitor.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_next_o;
  logic        instr_ready_i = 1'b0;
  logic [2:0]  count_o;

  fetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_next_o     (pc_next_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_next;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  bit          run = 1'b0;
  bit          pushed_now = 1'b0;
  logic [31:0] exp_fetch_pc = RESET_PC;
  logic [31:0] held_addr = '0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  bit          stale = 1'b0;
  int          age = 0;
  int          lat = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a >> 2) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_fetch_pc = RESET_PC;
    prev_req     = 1'b0;
    prev_ack     = 1'b0;
    stale        = 1'b0;
    age          = 0;
    pushed_now   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req"},   32'(mem_req_o),     32'd0);
    check({tag, "_mem_addr"},  mem_addr_o,         RESET_PC);
    check({tag, "_valid"},     32'(instr_valid_o), 32'd0);
    check({tag, "_instr"},     instr_o,            32'd0);
    check({tag, "_pc_next"},   pc_next_o,          32'd0);
    check({tag, "_count"},     32'(count_o),       32'd0);
  endtask

  // One clock cycle of memory response and pipeline-side stimulus.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
    bit ack;
    @(posedge clk_i);
    #1;
    check("count", 32'(count_o), 32'(sb.size()));
    if (mem_req_o) begin
      if (!prev_req || prev_ack) begin
        check("req_addr", mem_addr_o, exp_fetch_pc);
        held_addr = mem_addr_o;
        age       = 0;
        lat       = $urandom_range(lat_hi, lat_lo);
      end else begin
        check("addr_hold", mem_addr_o, held_addr);
      end
    end else begin
      check("idle_only_when_full", 32'(sb.size()), 32'(DEPTH));
    end

    ack           = mem_req_o && (age >= lat);
    mem_ack_i     = ack;
    mem_data_i    = ack ? word_at(mem_addr_o) : $urandom;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    pushed_now    = 1'b0;

    if (redir) begin
      sb.delete();
      stale        = mem_req_o && !ack;
      exp_fetch_pc = tgt & ~32'd3;
    end else if (ack && !stale) begin
      sb.push_back({word_at(mem_addr_o), mem_addr_o + 32'd4});
      pushed_now   = 1'b1;
      exp_fetch_pc = mem_addr_o + 32'd4;
    end
    if (ack) stale = 1'b0;

    prev_req = mem_req_o;
    prev_ack = ack;
    age++;
  endtask

  task automatic reset_mid_wait();
    int budget;
    budget = 0;
    lat_lo = 3;
    lat_hi = 3;
    while (!(mem_req_o && !mem_ack_i) && budget < 20) begin
      step(1'b1, 1'b0, 32'h0);
      budget++;
    end
    if (budget >= 20) begin
      vectors++;
      errors++;
      $display("FAIL wait_for_request: got no outstanding request expected one within 20 cycles");
    end
    #2;
    run   = 1'b0;
    rst_i = 1'b0;
    #1;
    check_reset_values("async_rst");
    mem_ack_i     = 1'b0;
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    run = 1'b1;
  endtask

  // Monitor: compares every accepted instruction against the scoreboard.
  always @(negedge clk_i) begin : monitor
    int   committed;
    logic expv;
    exp_t e;
    if (run && rst_i && !redirect_i) begin
      committed = sb.size() - (pushed_now ? 1 : 0);
      expv      = (committed > 0);
`ifdef PFQ_BYPASS_EN
      if (pushed_now) expv = 1'b1;
`endif
      check("instr_valid", 32'(instr_valid_o), 32'(expv));
      if (instr_valid_o && instr_ready_i) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL pop_empty: got instr %h pc_next %h expected no instruction", instr_o, pc_next_o);
        end else begin
          e = sb.pop_front();
          check("instr", instr_o, e.instr);
          check("pc_next", pc_next_o, e.pc_next);
          $display("accept instr=%h pc_next=%h count=%0d", instr_o, pc_next_o, count_o);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stimulus
    int budget;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_values("por");
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    run = 1'b1;

    // Streaming with single-cycle ack
    lat_lo = 0; lat_hi = 0;
    repeat (12) step(1'b1, 1'b0, 32'h0);

    // Stall fills the queue, then drain across pointer wrap
    repeat (10) step(1'b0, 1'b0, 32'h0);
    repeat (16) step(1'b1, 1'b0, 32'h0);

    // Slow memory: ack after 3 wait cycles
    lat_lo = 3; lat_hi = 3;
    repeat (24) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset while a request is outstanding
    reset_mid_wait();

    // Redirect to 0x40 while the fetch of 0x08 is outstanding
    lat_lo = 3; lat_hi = 3;
    budget = 0;
    while (!(mem_req_o && mem_addr_o == 32'h8) && budget < 40) begin
      step(1'b1, 1'b0, 32'h0);
      budget++;
    end
    if (budget >= 40) begin
      vectors++;
      errors++;
      $display("FAIL reach_addr_8: got addr %h expected 00000008", mem_addr_o);
    end
    step(1'b1, 1'b1, 32'h0000_0041);
    repeat (20) step(1'b1, 1'b0, 32'h0);

    // Redirect coinciding with ack and pop
    lat_lo = 0; lat_hi = 0;
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0100);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // 32-bit wrap of the fetch PC
    step(1'b1, 1'b1, 32'hFFFF_FFF4);
    repeat (10) step(1'b1, 1'b0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      lat_lo = 0;
      lat_hi = (i % 600 < 300) ? 0 : 3;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    end
    repeat (2) step(1'b1, 1'b0, 32'h0);

    @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch unit that sits directly upstream of the IF/ID pipeline register. It replaces the combinational instruction-memory read with a handshaked fetch engine. It issues sequential word fetches to a multi-cycle instruction memory, buffers returned words with their PC+4 in a small queue, and presents one instruction per cycle to the IF/ID register. It discards in-flight work when the MEM stage redirects the PC on a taken branch.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous, active-low reset
- redirect_i  in  1  taken-branch redirect pulse from MEM stage (branch & zero)
- redirect_pc_i  in  32  redirect target (branch adder result)
- mem_req_o  out  1  fetch request to instruction memory
- mem_addr_o  out  32  word-aligned fetch address
- mem_ack_i  in  1  memory returns mem_data_i this cycle; completes request
- mem_data_i  in  32  fetched instruction word
- instr_valid_o  out  1  instr_o / pc_next_o valid
- instr_o  out  32  instruction at queue head
- pc_next_o  out  32  address of head instruction + 4
- instr_ready_i  in  1  IF/ID accepts head this cycle (low = stall)
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- States:
  - FETCH: no request outstanding.
  - WAIT: request outstanding.
  - DISCARD: outstanding request belongs to the flushed path.
- FETCH → WAIT: issue when count + pending < DEPTH. Assert mem_req_o with mem_addr_o = fetch_pc.
- Only one request may be outstanding.
- While waiting, mem_req_o and mem_addr_o are held stable until mem_ack_i; requests are never withdrawn.
- WAIT, mem_ack_i:
  - Push {mem_data_i, fetch_pc+4} into the queue and advance fetch_pc by 4 (32-bit wrap).
  - Return to FETCH, or reissue in the same cycle if space remains (back-to-back).
- Pop: instr_valid_o & instr_ready_i. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority):
  - Flush the queue (count=0, pointers reset) and set fetch_pc = redirect_pc_i.
  - If a request is outstanding and not acked this cycle, go to DISCARD.
  - If acked this cycle, drop the data and go to FETCH.
  - A pop in the same cycle is ignored.
- DISCARD: keep mem_req_o high at the old address. On ack, drop the data, go to FETCH, and issue at the redirect PC the next cycle.
- A redirect received in DISCARD only updates fetch_pc.
- redirect_pc_i[1:0] are ignored (forced 0).
- Pointers wrap modulo DEPTH. A push never occurs when full, because space is reserved at issue.

## Timing
- Reset values:
  - mem_req_o=0, mem_addr_o=RESET_PC
  - instr_valid_o=0, instr_o=0, pc_next_o=0, count_o=0
  - state FETCH, fetch_pc=RESET_PC
- Reset mid-request abandons it. The memory is reset by the same rst_i.
- First request is asserted in the first cycle after rst_i deasserts.
- Ack in cycle N → instr_valid_o in cycle N+1 (non-bypass).
- Redirect in cycle N → instr_valid_o=0 in N+1; new request in N+1 (FETCH) or the cycle after the stale ack (DISCARD).
- Steady state with single-cycle ack: one instruction per cycle.
- All outputs are registered except the bypass path below.

## Configuration
- PFQ_BYPASS_EN defined: when the queue is empty, mem_ack_i is high, and no redirect occurs, mem_data_i / fetch_pc+4 drive instr_o / pc_next_o combinationally with instr_valid_o=1 in the same cycle.
  - If instr_ready_i is high, the word is consumed and not stored.
  - Otherwise it is stored normally.
  - Latency 0.
- Undefined: no combinational path from memory to outputs; latency 1.

## Structure
- Package pfq_pkg holds:
  - state enum {FETCH, WAIT, DISCARD}
  - INSTR_BYTES=4 constant
  - 32-bit address/word typedefs
- Sub-module pfq_fifo handles storage, read/write pointers with wrap, and count, plus a flush input. The top level holds the FSM, fetch_pc and the bypass mux.

## Test plan
- Reset with RESET_PC=0 and always-ack memory returning addr>>2 → words 0,1,2,3 on consecutive cycles; pc_next_o 4,8,12,16.
- instr_ready_i low for 10 cycles, DEPTH=4 → count_o saturates at 4, mem_req_o low. Ready high → instr_valid_o stays high every cycle, no words lost or duplicated, order preserved across pointer wrap.
- Memory acks after 3 cycles → mem_addr_o stable while mem_req_o is high; one instruction every 4 cycles.
- Redirect to 0x40 while a request to 0x08 is outstanding → DISCARD, word from 0x08 dropped, next mem_addr_o=0x40, first instr_o=word(0x40) with pc_next_o=0x44.
- Redirect coinciding with ack and pop → queue empty next cycle, ack data dropped, count_o=0.
- rst_i asserted mid-WAIT → all outputs at reset values asynchronously; fetch restarts at RESET_PC. With PFQ_BYPASS_EN: empty queue plus ack → instr_valid_o high in the ack cycle.
